// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes and key-schedule tables,
// plus the table-driven helper functions used by the data path.
package des_pkg;

  localparam int DES_ROUNDS = 16;
  localparam int KEY_W      = 48;
  localparam int EXKEY_W    = DES_ROUNDS * KEY_W;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Tables hold 1-based DES bit numbers, bit 1 being the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is four 16-nibble rows, row 0 / column 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  // Row comes from the outer bits of the group, column from the inner four.
  function automatic logic [3:0] sbox_lu(input logic [2:0] n, input logic [5:0] six);
    logic [5:0]   idx;
    logic [255:0] t;
    idx = {six[5], six[0], six[4:1]};
    t   = SBOX[n] >> {6'd63 - idx, 2'b00};
    return t[3:0];
  endfunction

endpackage

// File: rtl/des_if.sv
// Data-side handshake between a block source and the DES core.
interface des_if;
  import des_pkg::*;

  logic [63:0] i_din;
  logic        i_din_en;
  logic        i_decrypt;
  logic [63:0] o_dout;
  logic        o_dout_en;
  logic        o_busy;

  modport master (output i_din, i_din_en, i_decrypt, input o_dout, o_dout_en, o_busy);
  modport slave  (input i_din, i_din_en, i_decrypt, output o_dout, o_dout_en, o_busy);
endinterface

// File: rtl/des_f.sv
// Combinational DES round function f(R,K) = P(S(E(R) ^ K)).
module des_f
  import des_pkg::*;
(
  input  logic [31:0]      i_r,
  input  logic [KEY_W-1:0] i_k,
  output logic [31:0]      o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  assign w_x = e_exp(i_r) ^ i_k;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
      assign w_s[31-4*gi -: 4] = sbox_lu(3'(gi), w_x[47-6*gi -: 6]);
    end
  endgenerate

  assign o_f = p_perm(w_s);

endmodule

// File: rtl/des_crypt.sv
// Iterative DES core: one Feistel round per clock using externally held round
// keys; aborts without output if the key schedule drops key-ready mid-block.
module des_crypt
  import des_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [EXKEY_W-1:0] i_exkey,
  input  logic               i_key_ok,
  des_if.slave               bus
);

  state_t      r_state;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic [63:0] r_dout;
  logic        r_dout_en;

  logic [KEY_W-1:0] w_keys [DES_ROUNDS];
  logic [3:0]       w_ksel;
  logic [31:0]      w_f;
  logic [31:0]      w_l_new;
  logic [31:0]      w_r_new;

  // w_keys[n] is round key K(n+1); K1 sits in the top slice of the bus.
  generate
    for (genvar gi = 0; gi < DES_ROUNDS; gi++) begin : g_keys
      assign w_keys[gi] = i_exkey[EXKEY_W-1-KEY_W*gi -: KEY_W];
    end
  endgenerate

  assign w_ksel = r_dec ? (4'd15 - r_cnt) : r_cnt;

  des_f u_f (
    .i_r (r_r),
    .i_k (w_keys[w_ksel]),
    .o_f (w_f)
  );

  assign w_l_new = r_r;
  assign w_r_new = r_l ^ w_f;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_l       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_dec     <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
    end else begin
      r_dout_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_din_en && i_key_ok) begin
            {r_l, r_r} <= ip_perm(bus.i_din);
            r_dec      <= bus.i_decrypt;
            r_cnt      <= '0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Keys are not latched, so a rekey mid-block must discard the block.
          if (!i_key_ok) begin
            r_state <= ST_IDLE;
          end else begin
            r_l   <= w_l_new;
            r_r   <= w_r_new;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(DES_ROUNDS - 1)) begin
              r_dout    <= fp_perm({w_r_new, w_l_new});
              r_dout_en <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_dout    = r_dout;
  assign bus.o_dout_en = r_dout_en;
  assign bus.o_busy    = (r_state == ST_RUN);

endmodule

// File: tb/tb_des_crypt.sv
// Directed and randomized checks of des_crypt against a whole-block DES model
// that expands raw keys itself and undoes IP by inversion.
module tb_des_crypt;
  import des_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [767:0] exkey;
  logic         key_ok;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_pulse = 0;

  des_if bus();

  des_crypt dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_exkey  (exkey),
    .i_key_ok (key_ok),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_dout_en === 1'b1) n_pulse <= n_pulse + 1;

  function automatic logic [767:0] expand_key(input logic [63:0] key);
    logic [27:0]  c, d;
    logic [55:0]  cd;
    logic [47:0]  k;
    logic [767:0] ex;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      ex[767-48*r -: 48] = k;
    end
    return ex;
  endfunction

  function automatic logic [63:0] des_ref(input logic [767:0] ex, input logic [63:0] blk,
                                          input logic dec);
    logic [47:0] ks[$];
    logic [63:0] t, y;
    logic [31:0] l, r, nr, s, f;
    logic [47:0] x;
    int six, row, col;
    for (int i = 0; i < 16; i++) ks.push_back(ex[767-48*i -: 48]);
    if (dec) ks.reverse();
    for (int i = 0; i < 64; i++) t[63-i] = blk[64-IP_T[i]];
    l = t[63:32];
    r = t[31:0];
    foreach (ks[n]) begin
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ ks[n];
      for (int j = 0; j < 8; j++) begin
        six = int'(x[47-6*j -: 6]);
        row = ((six >> 4) & 2) | (six & 1);
        col = (six >> 1) & 15;
        s[31-4*j -: 4] = 4'((SBOX[j] >> (4 * (63 - (row * 16 + col)))) & 256'hF);
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
      nr = l ^ f;
      l  = r;
      r  = nr;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = t[63-i];
    return y;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] d, input logic dec);
    bus.i_din     = d;
    bus.i_decrypt = dec;
    bus.i_din_en  = 1'b1;
    tick();
    bus.i_din_en  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.o_dout_en !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_block(input string tag, input logic [63:0] d, input logic dec,
                           input logic [63:0] exp);
    int cyc;
    send(d, dec);
    check({tag, "/busy"}, 64'(bus.o_busy), 64'd1);
    wait_done(cyc);
    check({tag, "/latency"}, 64'(cyc), 64'd17);
    check({tag, "/dout"}, bus.o_dout, exp);
    check({tag, "/busy_low"}, 64'(bus.o_busy), 64'd0);
    tick();
    check({tag, "/one_pulse"}, 64'(bus.o_dout_en), 64'd0);
    check({tag, "/hold"}, bus.o_dout, exp);
  endtask

  initial begin
    logic [63:0] key, a, b, c, prev;
    logic        dec;
    int          cyc, p0;

    rst = 1'b1; key_ok = 1'b0; exkey = '0;
    bus.i_din = '0; bus.i_din_en = 1'b0; bus.i_decrypt = 1'b0;
    tick(); tick();
    check("reset/dout", bus.o_dout, 64'd0);
    check("reset/dout_en", 64'(bus.o_dout_en), 64'd0);
    check("reset/busy", 64'(bus.o_busy), 64'd0);
    rst = 1'b0;
    tick();

    // Known-answer vectors.
    exkey = expand_key(64'h133457799BBCDFF1); key_ok = 1'b1;
    tick();
    run_block("kat_enc", 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
    run_block("kat_dec", 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
    key_ok = 1'b0; exkey = expand_key(64'h0E329232EA6D0D73);
    tick();
    key_ok = 1'b1;
    run_block("kat_zero", 64'h8787878787878787, 1'b0, 64'h0);

    // Random keys, blocks and directions.
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom};
      a   = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      key_ok = 1'b0; exkey = expand_key(key);
      tick();
      key_ok = 1'b1;
      run_block("random", a, dec, des_ref(exkey, a, dec));
    end

    // Request while busy is dropped; request in the result cycle is taken.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    p0 = n_pulse;
    send(a, 1'b0);
    repeat (3) tick();
    send(b, 1'b1);
    wait_done(cyc);
    check("b2b/latency_a", 64'(cyc + 4), 64'd17);
    check("b2b/dout_a", bus.o_dout, des_ref(exkey, a, 1'b0));
    send(c, 1'b0);
    check("b2b/busy_c", 64'(bus.o_busy), 64'd1);
    wait_done(cyc);
    check("b2b/latency_c", 64'(cyc), 64'd17);
    check("b2b/dout_c", bus.o_dout, des_ref(exkey, c, 1'b0));
    repeat (3) tick();
    check("b2b/results", 64'(n_pulse - p0), 64'd2);

    // Key-ready drop before round 8 aborts the block.
    prev = bus.o_dout; p0 = n_pulse;
    send({$urandom, $urandom}, 1'b0);
    repeat (7) tick();
    key_ok = 1'b0;
    tick();
    check("abort/busy", 64'(bus.o_busy), 64'd0);
    check("abort/dout_en", 64'(bus.o_dout_en), 64'd0);
    key = {$urandom, $urandom};
    exkey = expand_key(key);
    repeat (25) tick();
    check("abort/dout_held", bus.o_dout, prev);
    check("abort/no_result", 64'(n_pulse - p0), 64'd0);
    key_ok = 1'b1;
    a = {$urandom, $urandom};
    run_block("rekey", a, 1'b0, des_ref(exkey, a, 1'b0));

    // Asynchronous reset mid-block, then a request with keys not ready.
    send({$urandom, $urandom}, 1'b1);
    repeat (5) tick();
    p0 = n_pulse;
    rst = 1'b1;
    #1;
    check("midrst/dout", bus.o_dout, 64'd0);
    check("midrst/dout_en", 64'(bus.o_dout_en), 64'd0);
    check("midrst/busy", 64'(bus.o_busy), 64'd0);
    tick();
    rst = 1'b0; key_ok = 1'b0;
    send({$urandom, $urandom}, 1'b0);
    check("nokey/busy", 64'(bus.o_busy), 64'd0);
    repeat (20) tick();
    check("nokey/no_result", 64'(n_pulse - p0), 64'd0);
    check("nokey/dout", bus.o_dout, 64'd0);
    key_ok = 1'b1;
    a = {$urandom, $urandom};
    run_block("after_rst", a, 1'b1, des_ref(exkey, a, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
